div32_seq: RTL and testbench

DIV32_SEQ -- requirements
Module: div32_seq

---
 rtl/div32_seq_if.sv | 36 +++
 rtl/div32_seq.sv | 135 +++++++++++++
 tb/tb_div32_seq.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/div32_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : div32_seq_if
//  Description : Request/response bundle for the sequential divider.
//                The requester side drives start, the signed select and the
//                operands. The divider side returns the registered remainder
//                (o_hi), the quotient (o_lo), busy, a one-cycle done pulse,
//                and the divide-by-zero flag.
//  Ports       : i_start, i_signed, i_a, i_b  (requester -> divider)
//                o_hi, o_lo, o_busy, o_done, o_dz (divider -> requester)
//  Revision    : 1.0 - initial release
// ============================================================================
interface div32_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_start;
    logic                  i_signed;
    logic [DATA_WIDTH-1:0] i_a;
    logic [DATA_WIDTH-1:0] i_b;
    logic [DATA_WIDTH-1:0] o_hi;
    logic [DATA_WIDTH-1:0] o_lo;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_dz;

    modport master (
        output i_start, i_signed, i_a, i_b,
        input  o_hi, o_lo, o_busy, o_done, o_dz
    );

    modport slave (
        input  i_start, i_signed, i_a, i_b,
        output o_hi, o_lo, o_busy, o_done, o_dz
    );
endinterface
`default_nettype wire

// File: rtl/div32_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div32_seq
//  Description : Sequential radix-2 restoring divider, signed or unsigned.
//                The operation takes a fixed 33 cycles from START to DONE,
//                and that count does not depend on the operand values.
//                The cycle sequence is: capture, then 32 restoring steps,
//                then one sign-fix cycle.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - div32_seq_if.slave (start/signed/a/b in,
//                       hi/lo/busy/done/dz out)
//  Revision    : 1.0 - initial release
// ============================================================================
module div32_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    div32_seq_if.slave       bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] c_LAST_STEP = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t r_state, w_next;

    logic [W-1:0]  r_a;      // original dividend, returned as HI on divide-by-zero
    logic [W-1:0]  r_dvs;    // divisor magnitude
    logic [W-1:0]  r_rem;    // partial remainder
    logic [W-1:0]  r_quo;    // dividend magnitude shifting out, quotient shifting in
    logic          r_qneg;
    logic          r_rneg;
    logic          r_bzero;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_hi;
    logic [W-1:0]  r_lo;
    logic          r_dz;
    logic          r_done;

    // Operand magnitudes and result signs are computed from the live inputs.
    // They are registered on the accepting edge.
    logic [W-1:0] w_amag, w_bmag;
    assign w_amag = (bus.i_signed && bus.i_a[W-1]) ? (~bus.i_a + 1'b1) : bus.i_a;
    assign w_bmag = (bus.i_signed && bus.i_b[W-1]) ? (~bus.i_b + 1'b1) : bus.i_b;

    // One restoring step. When the trial subtraction succeeds, the true
    // difference is smaller than the divisor, so a W-bit subtraction is exact.
    logic [W:0]   w_shift;
    logic         w_ge;
    logic [W-1:0] w_sub;
    assign w_shift = {r_rem, r_quo[W-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    assign w_sub   = w_shift[W-1:0] - r_dvs;

    logic w_accept;
    assign w_accept = (r_state == S_IDLE) && bus.i_start;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.i_start) w_next = S_RUN;
            S_RUN:   if (r_cnt == c_LAST_STEP) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_bzero <= 1'b0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_dz    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a     <= bus.i_a;
                r_dvs   <= w_bmag;
                r_rem   <= '0;
                r_quo   <= w_amag;
                r_qneg  <= bus.i_signed & (bus.i_a[W-1] ^ bus.i_b[W-1]);
                r_rneg  <= bus.i_signed & bus.i_a[W-1];
                r_bzero <= (bus.i_b == '0);
                r_cnt   <= '0;
            end else if (r_state == S_RUN) begin
                r_rem <= w_ge ? w_sub : w_shift[W-1:0];
                r_quo <= {r_quo[W-2:0], w_ge};
                r_cnt <= r_cnt + 1'b1;
            end else if (r_state == S_FIX) begin
                r_done <= 1'b1;
                r_dz   <= r_bzero;
                if (r_bzero) begin
                    r_lo <= '1;
                    r_hi <= r_a;
                end else begin
                    // The most-negative / -1 case needs no special handling.
                    // Its magnitude quotient is 2^(W-1), and negating that
                    // value gives the same bit pattern.
                    r_lo <= r_qneg ? (~r_quo + 1'b1) : r_quo;
                    r_hi <= r_rneg ? (~r_rem + 1'b1) : r_rem;
                end
            end
        end
    end

    assign bus.o_hi   = r_hi;
    assign bus.o_lo   = r_lo;
    assign bus.o_dz   = r_dz;
    assign bus.o_done = r_done;
    assign bus.o_busy = (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_div32_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div32_seq
//  Description : Directed self-checking bench for div32_seq, with
//                hand-computed expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div32_seq;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    div32_seq_if #(.DATA_WIDTH(32)) bus ();

    div32_seq #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request at the falling edge. The request is sampled by the next
    // rising edge, and the drive is removed 1 time unit after that edge.
    task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.i_start  = 1'b1;
        bus.i_signed = sg;
        bus.i_a      = a;
        bus.i_b      = b;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
    endtask

    // Count rising edges until done is observed. The count is bounded by a
    // cycle limit.
    task automatic wait_done(output int n);
        n = 0;
        while (bus.o_done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic run_op(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi, input logic exp_dz);
        int n;
        issue(sg, a, b);
        check({tag, " busy"}, {31'd0, bus.o_busy}, 32'd1);
        wait_done(n);
        check({tag, " latency"}, n, 32'd33);
        check({tag, " lo"}, bus.o_lo, exp_lo);
        check({tag, " hi"}, bus.o_hi, exp_hi);
        check({tag, " dz"}, {31'd0, bus.o_dz}, {31'd0, exp_dz});
        check({tag, " busy@done"}, {31'd0, bus.o_busy}, 32'd0);
        @(posedge clk);
        #1 check({tag, " single done"}, {31'd0, bus.o_done}, 32'd0);
    endtask

    initial begin : stim
        int n;
        int seen;
        bus.i_start  = 1'b0;
        bus.i_signed = 1'b0;
        bus.i_a      = '0;
        bus.i_b      = '0;
        rst          = 1'b1;

        // A start presented while reset is high must be ignored.
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_a = 32'd50;
        bus.i_b = 32'd5;
        repeat (2) @(posedge clk);
        #1 bus.i_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset hi",   bus.o_hi, 32'd0);
        check("reset lo",   bus.o_lo, 32'd0);
        check("reset busy", {31'd0, bus.o_busy}, 32'd0);
        check("reset done", {31'd0, bus.o_done}, 32'd0);
        check("reset dz",   {31'd0, bus.o_dz}, 32'd0);

        run_op("u200/20",  1'b0, 32'd200,       32'd20,        32'd10,        32'd0,         1'b0);
        run_op("uE1/70",   1'b0, 32'hE1000000,  32'h70000000,  32'd2,         32'h01000000,  1'b0);
        run_op("s-7/2",    1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0);
        run_op("s7/-2",    1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0);
        run_op("s-45/-15", 1'b1, 32'hFFFFFFD3,  32'hFFFFFFF1,  32'd3,         32'd0,         1'b0);
        run_op("s ovf",    1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0);
        run_op("u ovfops", 1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0);
        run_op("u dz",     1'b0, 32'h12345678,  32'd0,         32'hFFFFFFFF,  32'h12345678,  1'b1);
        run_op("s dz",     1'b1, 32'h12345678,  32'd0,         32'hFFFFFFFF,  32'h12345678,  1'b1);
        run_op("dz clear", 1'b0, 32'd9,         32'd4,         32'd2,         32'd1,         1'b0);
        run_op("uFFFF/3",  1'b0, 32'hFFFFFFFF,  32'd3,         32'h55555555,  32'd0,         1'b0);

        // Back-to-back: assert start again in the done cycle.
        issue(1'b0, 32'd1000, 32'd7);
        // Results from the previous operation are held while this one runs.
        check("hold lo", bus.o_lo, 32'h55555555);
        wait_done(n);
        check("b2b first latency", n, 32'd33);
        check("b2b first lo", bus.o_lo, 32'd142);
        check("b2b first hi", bus.o_hi, 32'd6);
        bus.i_start  = 1'b1;
        bus.i_signed = 1'b1;
        bus.i_a      = 32'hFFFFFF9C;   // -100
        bus.i_b      = 32'd7;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        check("b2b busy", {31'd0, bus.o_busy}, 32'd1);
        wait_done(n);
        check("b2b second latency", n, 32'd33);
        check("b2b second lo", bus.o_lo, 32'hFFFFFFF2);   // -14
        check("b2b second hi", bus.o_hi, 32'hFFFFFFFE);   // -2
        @(posedge clk);

        // A start pulsed during an operation must be ignored.
        issue(1'b0, 32'd81, 32'd9);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_a = 32'd77;
        bus.i_b = 32'd10;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        n = 5;
        while (bus.o_done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        check("ignored start latency", n, 32'd33);
        check("ignored start lo", bus.o_lo, 32'd9);
        check("ignored start hi", bus.o_hi, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (bus.o_done === 1'b1) seen++;
        end
        check("ignored start extra done", seen, 32'd0);

        // Reset during an operation aborts it, and no done pulse follows.
        issue(1'b0, 32'd500, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort hi",   bus.o_hi, 32'd0);
        check("abort lo",   bus.o_lo, 32'd0);
        check("abort busy", {31'd0, bus.o_busy}, 32'd0);
        check("abort dz",   {31'd0, bus.o_dz}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (bus.o_done === 1'b1) seen++;
        end
        check("abort no done", seen, 32'd0);
        run_op("post-rst 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
